// File: rtl/event_serializer_arb_pkg.sv
// Purpose: shared event-bus constants and width helper for the event serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package event_serializer_arb_pkg;

    // Default source count and event-number width of the serialized event bus.
    localparam int EVT_COUNT      = 16;
    localparam int EVT_COUNT_BITS = 4;

    // Ceiling log2, used for derived widths at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/event_serializer_arb_pick.sv
// Purpose: round-robin pick; the first set request at or after base, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req (request vector), base (search start index, < N),
//        grant (selected index), any_grant (at least one request set).
module rr_priority_pick
    import event_serializer_arb_pkg::*;
#(
    parameter int N = EVT_COUNT,
    parameter int W = EVT_COUNT_BITS
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] grant,
    output logic         any_grant
);

    // Wide enough to hold base + offset (< 2*N) before the modulo fold.
    localparam int SUM_W = clog2(2 * N);

    logic [N-1:0]     rot;
    logic [SUM_W-1:0] off;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // Rotating the doubled vector puts req[base] at bit 0, so the lowest
        // set bit of rot is the distance from base to the winner.
        rot = N'({req, req} >> base);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SUM_W'(i);
            end
        end
        sum = SUM_W'(base) + off;
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
        grant     = W'(sum);
        any_grant = |req;
    end

endmodule

// File: rtl/event_serializer_arb.sv
// Purpose: serializes one-deep per-source pending events onto a round-robin event-number stream.
// Latency: event handshake in cycle 0 appears on m_evno_* in cycle 2; one event per cycle sustained.
// Backpressure: output register holds while m_evno_ready=0; a source is stalled only while its pending bit is set.
// Ports: clk/rst_n; cfg_enable (per-source enable), s_event_valid/s_event_ready (per-source handshake),
//        m_evno_data/m_evno_valid/m_evno_ready (serialized stream), stat_pending, stat_busy.
module event_serializer_arb
    import event_serializer_arb_pkg::*;
#(
    parameter int COUNT      = EVT_COUNT,
    parameter int COUNT_BITS = EVT_COUNT_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COUNT-1:0]      cfg_enable,
    input  logic [COUNT-1:0]      s_event_valid,
    output logic [COUNT-1:0]      s_event_ready,
    output logic [COUNT_BITS-1:0] m_evno_data,
    output logic                  m_evno_valid,
    input  logic                  m_evno_ready,
    output logic [COUNT-1:0]      stat_pending,
    output logic                  stat_busy
);

    logic [COUNT-1:0]      pending_q,    pending_d;
    logic [COUNT_BITS-1:0] rr_ptr_q,     rr_ptr_d;
    logic [COUNT_BITS-1:0] evno_data_q,  evno_data_d;
    logic                  evno_valid_q, evno_valid_d;

    logic [COUNT-1:0]      eligible;
    logic [COUNT_BITS-1:0] grant;
    logic                  any_grant;
    logic                  load;

    // A disabled source is always ready so its events drain and vanish.
    assign s_event_ready = ~pending_q | ~cfg_enable;
    assign eligible      = pending_q & cfg_enable;

    rr_priority_pick #(
        .N (COUNT),
        .W (COUNT_BITS)
    ) u_pick (
        .req       (eligible),
        .base      (rr_ptr_q),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_comb begin
        load         = ~evno_valid_q | m_evno_ready;
        // Masking with cfg_enable drops pending bits of sources disabled meanwhile.
        pending_d    = (pending_q & cfg_enable) | (s_event_valid & s_event_ready & cfg_enable);
        rr_ptr_d     = rr_ptr_q;
        evno_data_d  = evno_data_q;
        evno_valid_d = evno_valid_q;
        if (load) begin
            evno_valid_d = any_grant;
            if (any_grant) begin
                evno_data_d = grant;
                // A granted source cannot handshake this cycle (ready=0), so
                // clearing here never races with a new set.
                pending_d   = pending_d & ~(COUNT'(1) << grant);
                rr_ptr_d    = (grant == COUNT_BITS'(COUNT - 1)) ? '0 : grant + COUNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            evno_data_q  <= '0;
            evno_valid_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            evno_data_q  <= evno_data_d;
            evno_valid_q <= evno_valid_d;
        end
    end

    assign m_evno_data  = evno_data_q;
    assign m_evno_valid = evno_valid_q;
    assign stat_pending = pending_q;
    assign stat_busy    = (|pending_q) | evno_valid_q;

endmodule
